// File: rtl/step_pulse_gen.sv
// Velocity word to step/dir pulses via phase accumulator, with pulse width, gap and dir-setup timing.
// Optional STEP_OVERRUN_DETECT_EN adds a sticky o_overrun flag for dropped step requests.
module step_pulse_gen #(
  parameter int ACC_W      = 16,
  parameter int PULSE_W    = 4,
  parameter int DIR_SETUP  = 2,
  parameter int REV_COUNTS = 1496
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic signed [15:0] i_value,
  input  logic               i_valid,
  input  logic               i_enable,
  output logic               o_step,
  output logic               o_dir,
  output logic [15:0]        o_position,
  output logic               o_rev_tick,
  output logic               o_busy
`ifdef STEP_OVERRUN_DETECT_EN
  ,
  output logic               o_overrun
`endif
);

  localparam int CMAX  = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, GAP} state_t;

  state_t             state;
  logic [14:0]        vel_mag;
  logic               tgt_dir;
  logic [ACC_W-1:0]   acc;
  logic [1:0]         pending;
  logic [CNT_W-1:0]   cnt;

  logic [15:0]        neg_val;
  logic [14:0]        mag_in;
  logic [ACC_W:0]     acc_sum;
  logic               carry;
  logic [2:0]         eff;
  logic [2:0]         pend_sum;
  logic               go_high;
  logic               go_setup;
  logic               pw_done;

  // -32768 has no positive counterpart in 16 bits, so it saturates.
  always_comb begin
    neg_val = 16'(~i_value + 16'sd1);
    if (i_value == 16'sh8000)  mag_in = 15'h7fff;
    else if (i_value[15])      mag_in = neg_val[14:0];
    else                       mag_in = i_value[14:0];
  end

  always_comb begin
    acc_sum  = {1'b0, acc} + (ACC_W+1)'(vel_mag);
    carry    = i_enable & acc_sum[ACC_W];
    eff      = {1'b0, pending} + {2'b00, carry};
    pw_done  = (cnt == CNT_W'(PULSE_W - 1));
    go_high  = 1'b0;
    go_setup = 1'b0;
    case (state)
      IDLE: if (eff != 3'd0) begin
        if (o_dir == tgt_dir) go_high  = 1'b1;
        else                  go_setup = 1'b1;
      end
      SETUP: go_high = (o_dir == tgt_dir) && (cnt == CNT_W'(DIR_SETUP - 1));
      // A matching request may chain straight out of GAP to keep the 2*PULSE_W period.
      GAP:   go_high = pw_done && (eff != 3'd0) && (o_dir == tgt_dir);
      default: ;
    endcase
    pend_sum = eff - {2'b00, go_high};
  end

  assign o_busy = (state != IDLE) || (pending != 2'd0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      vel_mag    <= '0;
      tgt_dir    <= 1'b1;
      acc        <= '0;
      pending    <= '0;
      cnt        <= '0;
      o_step     <= 1'b0;
      o_dir      <= 1'b1;
      o_position <= '0;
      o_rev_tick <= 1'b0;
`ifdef STEP_OVERRUN_DETECT_EN
      o_overrun  <= 1'b0;
`endif
    end else begin
      o_rev_tick <= 1'b0;
      if (i_valid) begin
        vel_mag <= mag_in;
        tgt_dir <= ~i_value[15];
      end
      if (i_enable) acc <= acc_sum[ACC_W-1:0];
      pending <= (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
`ifdef STEP_OVERRUN_DETECT_EN
      if (i_valid && i_value == 16'sd0)                o_overrun <= 1'b0;
      else if (carry && pending == 2'd3 && !go_high)   o_overrun <= 1'b1;
`endif
      if (go_high) begin
        state  <= HIGH;
        cnt    <= '0;
        o_step <= 1'b1;
        if (o_dir) begin
          if (o_position == 16'(REV_COUNTS - 1)) begin
            o_position <= '0;
            o_rev_tick <= 1'b1;
          end else o_position <= o_position + 16'd1;
        end else begin
          if (o_position == 16'd0) begin
            o_position <= 16'(REV_COUNTS - 1);
            o_rev_tick <= 1'b1;
          end else o_position <= o_position - 16'd1;
        end
      end else begin
        case (state)
          IDLE: if (go_setup) begin
            state <= SETUP;
            o_dir <= tgt_dir;
            cnt   <= '0;
          end
          // A further target flip during setup restarts the setup window.
          SETUP: if (o_dir != tgt_dir) begin
            o_dir <= tgt_dir;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
          HIGH: if (pw_done) begin
            state  <= GAP;
            o_step <= 1'b0;
            cnt    <= '0;
          end else cnt <= cnt + 1'b1;
          GAP: if (pw_done) state <= IDLE;
               else         cnt   <= cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Randomized bench for step_pulse_gen: timestamp-based reference model feeds a per-cycle scoreboard.
module tb_step_pulse_gen;

  localparam int PW  = 4;
  localparam int DS  = 2;
  localparam int REV = 1496;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b0;
  logic signed [15:0] i_value = '0;
  logic               i_valid = 1'b0;
  logic               i_enable = 1'b0;
  logic               o_step, o_dir, o_rev_tick, o_busy;
  logic [15:0]        o_position;
`ifdef STEP_OVERRUN_DETECT_EN
  logic               o_overrun;
`endif

  step_pulse_gen #(.ACC_W(16), .PULSE_W(PW), .DIR_SETUP(DS), .REV_COUNTS(REV)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_value(i_value), .i_valid(i_valid),
    .i_enable(i_enable), .o_step(o_step), .o_dir(o_dir), .o_position(o_position),
    .o_rev_tick(o_rev_tick), .o_busy(o_busy)
`ifdef STEP_OVERRUN_DETECT_EN
    , .o_overrun(o_overrun)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int cyc; bit step; bit dir; int pos; bit tick; bit busy; bit ovr;
  } snap_t;

  snap_t exp_q[$];
  int vectors = 0;
  int errors  = 0;

  // Reference model: tracks when the last step rose and when setup ends, not FSM states.
  initial begin
    int now = 0, acc = 0, mag = 0, pend = 0, pos = 0, last_rise = 0, setup_end = 0;
    int eff, d, sv;
    bit tgt = 1, dir = 1, have_rise = 0, in_setup = 0, ovr = 0, tick = 0, carry, rise;
    snap_t s;
    forever begin
      @(posedge i_clk);
      now++;
      if (!i_reset) begin
        acc = 0; mag = 0; pend = 0; pos = 0; tgt = 1; dir = 1;
        have_rise = 0; in_setup = 0; ovr = 0; tick = 0;
      end else begin
        carry = 0;
        if (i_enable) begin
          acc += mag;
          if (acc >= 65536) begin carry = 1; acc -= 65536; end
        end
        eff  = pend + int'(carry);
        rise = 0;
        d    = now - last_rise;
        if (in_setup) begin
          if (tgt != dir) begin dir = tgt; setup_end = now + DS; end
          else if (now == setup_end) rise = 1;
        end else if (!have_rise || d > 2*PW) begin
          if (eff > 0) begin
            if (dir == tgt) rise = 1;
            else begin dir = tgt; in_setup = 1; setup_end = now + DS; end
          end
        end else if (d == 2*PW && eff > 0 && dir == tgt) rise = 1;
        tick = 0;
        if (rise) begin
          in_setup = 0; have_rise = 1; last_rise = now;
          if (dir) begin
            if (pos == REV-1) begin pos = 0; tick = 1; end else pos++;
          end else begin
            if (pos == 0) begin pos = REV-1; tick = 1; end else pos--;
          end
        end
        if (i_valid && i_value == 0) ovr = 0;
        else if (carry && pend == 3 && !rise) ovr = 1;
        pend = eff - int'(rise);
        if (pend > 3) pend = 3;
        if (i_valid) begin
          sv  = int'(i_value);
          mag = (sv < 0) ? -sv : sv;
          if (mag > 32767) mag = 32767;
          tgt = (sv >= 0);
        end
      end
      s.cyc  = now;
      s.step = have_rise && (now - last_rise) < PW;
      s.dir  = dir;
      s.pos  = pos;
      s.tick = tick;
      s.busy = (pend > 0) || in_setup || (have_rise && (now - last_rise) < 2*PW);
      s.ovr  = ovr;
      exp_q.push_back(s);
    end
  end

  // Monitor: one expected snapshot per clock, compared just after the edge.
  initial begin
    snap_t e;
    bit bad;
    forever begin
      @(posedge i_clk); #1;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got output cycle with no expected entry");
      end else begin
        e = exp_q.pop_front();
        bad = (o_step !== e.step) || (o_dir !== e.dir) || (o_position !== 16'(e.pos)) ||
              (o_rev_tick !== e.tick) || (o_busy !== e.busy);
`ifdef STEP_OVERRUN_DETECT_EN
        bad = bad || (o_overrun !== e.ovr);
`endif
        if (bad) begin
          errors++;
          $display("FAIL cycle_%0d step/dir/pos/tick/busy: got %b/%b/%0d/%b/%b want %b/%b/%0d/%b/%b",
                   e.cyc, o_step, o_dir, o_position, o_rev_tick, o_busy,
                   e.step, e.dir, e.pos, e.tick, e.busy);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic load(input int v);
    i_value = 16'(v);
    i_valid = 1'b1;
    cyc(1);
    i_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b0;
    cyc(n);
    i_reset = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    vectors++;
    if (o_step !== 1'b0 || o_dir !== 1'b1 || o_position !== 16'd0 ||
        o_rev_tick !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got step/dir/pos/tick/busy %b/%b/%0d/%b/%b want 0/1/0/0/0",
               tag, o_step, o_dir, o_position, o_rev_tick, o_busy);
    end
  endtask

  task automatic wait_step(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge i_clk);
      if (o_step) begin ok = 1; break; end
    end
  endtask

  initial begin
    bit ok;
    int v;
    i_reset = 1'b0;
    cyc(3);
    check_reset_state("reset_state");
    i_reset = 1'b1;

    // Forward cadence, then reversal, then wrap both ways.
    i_enable = 1'b1;
    load(4096);
    cyc(80);
    load(-4096);
    cyc(80);
    do_reset(2);
    load(-4096);
    cyc(40);
    load(4096);
    cyc(60);

    // Saturated rates in both directions.
    load(32767);
    cyc(100);
    load(-32768);
    cyc(100);
    load(0);
    cyc(40);

    // Reset in the second cycle of a HIGH pulse.
    do_reset(2);
    load(4096);
    wait_step(100, ok);
    if (!ok) begin
      vectors++; errors++;
      $display("FAIL wait_step: got no o_step within 100 cycles want a rising step");
    end
    cyc(1);
    i_reset = 1'b0;
    cyc(1);
    check_reset_state("reset_mid_high");
    i_reset = 1'b1;
    load(4096);
    cyc(60);

    // Randomized segments: velocity, enable, occasional reset.
    for (int s = 0; s < 50; s++) begin
      case ($urandom_range(0, 9))
        0: v = 0;
        1: v = 32767;
        2: v = -32768;
        3, 4, 5: begin v = int'($urandom_range(0, 20000)); if ($urandom_range(0, 1) == 1) v = -v; end
        default: begin v = int'($urandom_range(0, 32767)); if ($urandom_range(0, 1) == 1) v = -v; end
      endcase
      i_enable = ($urandom_range(0, 3) != 0);
      load(v);
      cyc($urandom_range(5, 60));
      if ($urandom_range(0, 3) == 0) begin
        i_enable = ~i_enable;
        cyc($urandom_range(3, 20));
      end
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 3));
    end

    i_enable = 1'b0;
    cyc(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
